// File: rtl/xdma_axi_write_bridge.sv
// AXI4 write-only slave that turns AW/W bursts into reqrsp write requests.
// AW and W are decoupled by an AW FIFO; B responses are queued in a pending-B FIFO.

package xdma_axi_write_bridge_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 64;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned IdW   = 4;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [DataW-1:0] data_t;
  typedef logic [StrbW-1:0] strb_t;
  typedef logic [IdW-1:0]   axi_id_t;

  typedef struct packed {
    axi_id_t     id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
  } axi_aw_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } axi_w_t;

  typedef struct packed {
    axi_id_t    id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    axi_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ar_t;

  typedef struct packed {
    axi_id_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMin  = 4'h7
  } amo_op_e;

  typedef struct packed {
    addr_t      addr;
    logic       write;
    amo_op_e    amo;
    data_t      data;
    strb_t      strb;
    logic [2:0] size;
  } reqrsp_q_t;

  typedef struct packed {
    data_t data;
    logic  error;
  } reqrsp_p_t;

  typedef struct packed {
    reqrsp_q_t q;
    logic      q_valid;
    logic      p_ready;
  } reqrsp_req_t;

  typedef struct packed {
    reqrsp_p_t p;
    logic      p_valid;
    logic      q_ready;
  } reqrsp_rsp_t;

endpackage

module xdma_axi_write_bridge #(
  parameter type axi_in_req_t  = xdma_axi_write_bridge_pkg::axi_req_t,
  parameter type axi_in_resp_t = xdma_axi_write_bridge_pkg::axi_resp_t,
  parameter type data_t        = xdma_axi_write_bridge_pkg::data_t,
  parameter type addr_t        = xdma_axi_write_bridge_pkg::addr_t,
  parameter type axi_id_t      = xdma_axi_write_bridge_pkg::axi_id_t,
  parameter type strb_t        = xdma_axi_write_bridge_pkg::strb_t,
  parameter type reqrsp_req_t  = xdma_axi_write_bridge_pkg::reqrsp_req_t,
  parameter type reqrsp_rsp_t  = xdma_axi_write_bridge_pkg::reqrsp_rsp_t,
  parameter int unsigned AwDepth = 4,
  parameter int unsigned BDepth  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         busy_o,
  output logic         last_o,
  input  axi_in_req_t  axi_req_i,
  output axi_in_resp_t axi_rsp_o,
  output reqrsp_req_t  reqrsp_req_o,
  input  reqrsp_rsp_t  reqrsp_rsp_i
);

  localparam int unsigned AddrW  = $bits(addr_t);
  localparam int unsigned AwIdxW = (AwDepth > 1) ? $clog2(AwDepth) : 1;
  localparam int unsigned AwCntW = $clog2(AwDepth + 1);
  localparam int unsigned BIdxW  = (BDepth > 1) ? $clog2(BDepth) : 1;
  localparam int unsigned BCntW  = $clog2(BDepth + 1);

  typedef struct packed {
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    axi_id_t    id;
    logic [5:0] atop;
    logic       lock;
    logic [3:0] qos;
  } aw_entry_t;

  typedef struct packed {
    axi_id_t    id;
    logic [1:0] resp;
  } b_entry_t;

  aw_entry_t             aw_mem [1 << AwIdxW];
  aw_entry_t             aw_head;
  aw_entry_t             aw_entry;
  logic [AwIdxW-1:0]     aw_wptr_q, aw_rptr_q;
  logic [AwCntW-1:0]     aw_cnt_q;
  logic                  aw_full, aw_empty, aw_push, aw_pop;

  b_entry_t              b_mem [1 << BIdxW];
  b_entry_t              b_head;
  b_entry_t              b_entry;
  logic [BIdxW-1:0]      b_wptr_q, b_rptr_q;
  logic [BCntW-1:0]      b_cnt_q;
  logic                  b_full, b_empty, b_push, b_pop;

  logic                  first_q;
  logic [7:0]            cnt_q;
  addr_t                 addr_q;
  logic [7:0]            beat_cnt;
  addr_t                 beat_addr;
  logic                  beat_last, beat_err, issue, beat_hs;
  addr_t                 nb, base, wrap_mask, next_addr;
  data_t                 w_data;
  strb_t                 w_strb;

  // AW metadata FIFO; head is only visible once registered
  assign aw_full  = (aw_cnt_q == AwCntW'(AwDepth));
  assign aw_empty = (aw_cnt_q == '0);
  assign aw_push  = axi_req_i.aw_valid && !aw_full;
  assign aw_pop   = beat_hs && beat_last;
  assign aw_head  = aw_mem[aw_rptr_q];

  always_comb begin
    aw_entry       = '0;
    aw_entry.addr  = axi_req_i.aw.addr;
    aw_entry.len   = axi_req_i.aw.len;
    aw_entry.size  = axi_req_i.aw.size;
    aw_entry.burst = axi_req_i.aw.burst;
    aw_entry.id    = axi_req_i.aw.id;
    aw_entry.atop  = axi_req_i.aw.atop;
    aw_entry.lock  = axi_req_i.aw.lock;
    aw_entry.qos   = axi_req_i.aw.qos;
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_mem[aw_wptr_q] <= aw_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wptr_q <= '0;
      aw_rptr_q <= '0;
      aw_cnt_q  <= '0;
    end else begin
      if (aw_push)
        aw_wptr_q <= (aw_wptr_q == AwIdxW'(AwDepth - 1)) ? '0 : aw_wptr_q + AwIdxW'(1);
      if (aw_pop)
        aw_rptr_q <= (aw_rptr_q == AwIdxW'(AwDepth - 1)) ? '0 : aw_rptr_q + AwIdxW'(1);
      if (aw_push && !aw_pop)      aw_cnt_q <= aw_cnt_q + AwCntW'(1);
      else if (!aw_push && aw_pop) aw_cnt_q <= aw_cnt_q - AwCntW'(1);
    end
  end

  // Beat engine: the first beat of a head takes its fields straight from the FIFO,
  // so the next burst issues the cycle after the previous pop.
  assign beat_cnt  = first_q ? aw_head.len  : cnt_q;
  assign beat_addr = first_q ? aw_head.addr : addr_q;
  assign beat_last = (beat_cnt == 8'd0);
  assign beat_err  = (aw_head.atop != '0) || (aw_head.burst == 2'b11);
  assign issue     = !aw_empty && axi_req_i.w_valid && (!beat_last || !b_full);
  assign beat_hs   = issue && (beat_err || reqrsp_rsp_i.q_ready);

  always_comb begin
    nb        = AddrW'(1) << aw_head.size;
    base      = beat_addr & ~(nb - AddrW'(1));
    wrap_mask = (AddrW'({1'b0, aw_head.len} + 9'd1) << aw_head.size) - AddrW'(1);
    next_addr = base + nb;
    case (aw_head.burst)
      2'b00:   next_addr = beat_addr;
      2'b10:   next_addr = (base & ~wrap_mask) | ((base + nb) & wrap_mask);
      default: next_addr = base + nb;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= 1'b1;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
    end else if (beat_hs) begin
      if (beat_last) begin
        first_q <= 1'b1;
        cnt_q   <= 8'd0;
      end else begin
        first_q <= 1'b0;
        cnt_q   <= beat_cnt - 8'd1;
        addr_q  <= next_addr;
      end
    end
  end

  // Pending-B FIFO
  assign b_full   = (b_cnt_q == BCntW'(BDepth));
  assign b_empty  = (b_cnt_q == '0);
  assign b_push   = aw_pop;
  assign b_pop    = axi_req_i.b_ready && !b_empty;
  assign b_head   = b_mem[b_rptr_q];
  assign b_entry  = '{id: aw_head.id, resp: (beat_err ? 2'b10 : 2'b00)};

  always_ff @(posedge clk_i) begin
    if (b_push) b_mem[b_wptr_q] <= b_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_wptr_q <= '0;
      b_rptr_q <= '0;
      b_cnt_q  <= '0;
    end else begin
      if (b_push)
        b_wptr_q <= (b_wptr_q == BIdxW'(BDepth - 1)) ? '0 : b_wptr_q + BIdxW'(1);
      if (b_pop)
        b_rptr_q <= (b_rptr_q == BIdxW'(BDepth - 1)) ? '0 : b_rptr_q + BIdxW'(1);
      if (b_push && !b_pop)      b_cnt_q <= b_cnt_q + BCntW'(1);
      else if (!b_push && b_pop) b_cnt_q <= b_cnt_q - BCntW'(1);
    end
  end

  assign w_data = axi_req_i.w.data;
  assign w_strb = axi_req_i.w.strb;

  // Channel outputs
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = !aw_full;
    axi_rsp_o.w_ready  = beat_hs;
    axi_rsp_o.b_valid  = !b_empty;
    axi_rsp_o.b.id     = b_head.id;
    axi_rsp_o.b.resp   = b_head.resp;

    reqrsp_req_o         = '0;
    reqrsp_req_o.q_valid = issue && !beat_err;
    reqrsp_req_o.q.addr  = beat_addr;
    reqrsp_req_o.q.write = 1'b1;
    reqrsp_req_o.q.amo   = xdma_axi_write_bridge_pkg::AMONone;
    reqrsp_req_o.q.data  = w_data;
    reqrsp_req_o.q.strb  = w_strb;
    reqrsp_req_o.q.size  = aw_head.size;
    reqrsp_req_o.p_ready = 1'b1;
  end

  assign last_o = !aw_empty && beat_last;
  assign busy_o = axi_req_i.aw_valid | axi_req_i.w_valid | !aw_empty | !b_empty;

  logic unused;
  assign unused = ^{axi_req_i.ar, axi_req_i.ar_valid, axi_req_i.r_ready, axi_req_i.w.last,
                    axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.region,
                    aw_head.lock, aw_head.qos, reqrsp_rsp_i.p, reqrsp_rsp_i.p_valid};

endmodule

// File: tb/tb_xdma_axi_write_bridge.sv
// Randomised bench for xdma_axi_write_bridge against a burst-level reference model.

module tb_xdma_axi_write_bridge;
  import xdma_axi_write_bridge_pkg::*;

  localparam int unsigned AW_D = 4;
  localparam int unsigned B_D  = 1;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [5:0]  atop;
  } burst_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        busy_o, last_o;
  axi_req_t    axi_req;
  axi_resp_t   axi_rsp;
  reqrsp_req_t rq;
  reqrsp_rsp_t rs;

  axi_aw_t aw_s;
  logic    aw_valid_s;
  axi_w_t  w_s;
  logic    w_valid_s;
  logic    b_ready_s;
  logic    q_ready_s;

  int      qr_mode, br_mode;
  bit      gaps;
  int      cyc = 0;
  int      checks = 0, errors = 0;

  burst_t  aw_list[$];
  burst_t  w_list[$];
  burst_t  mq[$];
  bresp_t  exp_b[$];
  int      k = 0;
  logic [31:0] log_addr[$];
  logic        log_last[$];
  bresp_t      log_b[$];

  burst_t  m_cb;
  bit      m_head, m_last, m_err, m_can, m_qv, m_wr;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always_comb begin
    axi_req          = '0;
    axi_req.aw       = aw_s;
    axi_req.aw_valid = aw_valid_s;
    axi_req.w        = w_s;
    axi_req.w_valid  = w_valid_s;
    axi_req.b_ready  = b_ready_s;
    rs               = '0;
    rs.q_ready       = q_ready_s;
  end

  xdma_axi_write_bridge #(.AwDepth(AW_D), .BDepth(B_D)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .busy_o       (busy_o),
    .last_o       (last_o),
    .axi_req_i    (axi_req),
    .axi_rsp_o    (axi_rsp),
    .reqrsp_req_o (rq),
    .reqrsp_rsp_i (rs)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Address of beat k of a burst, stepping from the start address
  function automatic logic [31:0] beat_addr(input burst_t b, input int kk);
    logic [31:0] a, nb, base, mask;
    a = b.addr;
    for (int i = 0; i < kk; i++) begin
      nb   = 32'd1 << b.size;
      base = a - (a % nb);
      case (b.burst)
        2'd0: a = a;
        2'd2: begin
          mask = (32'(b.len) + 32'd1) * nb - 32'd1;
          a    = (base & ~mask) | ((base + nb) & mask);
        end
        default: a = base + nb;
      endcase
    end
    return a;
  endfunction

  // Reference model and per-cycle compare
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mq.delete();
      exp_b.delete();
      k = 0;
    end else begin
      chk("aw_ready", axi_rsp.aw_ready, mq.size() < AW_D);
      chk("b_valid", axi_rsp.b_valid, exp_b.size() > 0);
      if (exp_b.size() > 0) begin
        chk("b_id", axi_rsp.b.id, exp_b[0].id);
        chk("b_resp", axi_rsp.b.resp, exp_b[0].resp);
      end
      chk("busy", busy_o, aw_valid_s | w_valid_s | (mq.size() > 0) | (exp_b.size() > 0));
      m_head = mq.size() > 0;
      m_qv = 0; m_wr = 0; m_last = 0; m_err = 0;
      if (m_head) begin
        m_cb   = mq[0];
        m_last = (k == int'(m_cb.len));
        m_err  = (m_cb.atop != 0) || (m_cb.burst == 2'd3);
        m_can  = w_valid_s && (!m_last || exp_b.size() < B_D);
        m_qv   = m_can && !m_err;
        m_wr   = m_can && (m_err || q_ready_s);
      end
      chk("q_valid", rq.q_valid, m_qv);
      chk("w_ready", axi_rsp.w_ready, m_wr);
      chk("last_o", last_o, m_last);
      if (m_qv) begin
        chk("q_addr", rq.q.addr, beat_addr(m_cb, k));
        chk("q_data", rq.q.data, w_s.data);
        chk("q_strb", rq.q.strb, w_s.strb);
        chk("q_size", rq.q.size, m_cb.size);
        chk("q_write", rq.q.write, 1'b1);
        chk("q_amo", rq.q.amo, AMONone);
        chk("p_ready", rq.p_ready, 1'b1);
      end
      if (rq.q_valid && q_ready_s) begin
        log_addr.push_back(rq.q.addr);
        log_last.push_back(last_o);
      end
      if (m_head && w_valid_s && axi_rsp.w_ready) begin
        if (m_last) begin
          exp_b.push_back('{m_cb.id, m_err ? 2'b10 : 2'b00});
          void'(mq.pop_front());
          k = 0;
        end else k++;
      end
      if (axi_rsp.b_valid && b_ready_s && exp_b.size() > 0) begin
        log_b.push_back('{axi_rsp.b.id, axi_rsp.b.resp});
        void'(exp_b.pop_front());
      end
      if (aw_valid_s && axi_rsp.aw_ready)
        mq.push_back('{aw_s.addr, aw_s.len, aw_s.size, aw_s.burst, aw_s.id, aw_s.atop});
    end
  end

  // Ready generators
  initial begin
    q_ready_s = 1'b1;
    b_ready_s = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (qr_mode)
        0: q_ready_s = 1'b1;
        1: q_ready_s = ~q_ready_s;
        default: q_ready_s = 1'($urandom_range(0, 1));
      endcase
      case (br_mode)
        0: b_ready_s = 1'b1;
        1: b_ready_s = 1'($urandom_range(0, 1));
        default: b_ready_s = 1'b0;
      endcase
    end
  end

  task automatic drive_aw(input burst_t b);
    bit hs;
    int t0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    aw_s       = '0;
    aw_s.addr  = b.addr;
    aw_s.len   = b.len;
    aw_s.size  = b.size;
    aw_s.burst = b.burst;
    aw_s.id    = b.id;
    aw_s.atop  = b.atop;
    aw_valid_s = 1'b1;
    t0 = cyc;
    do begin
      @(negedge clk_i); hs = axi_rsp.aw_ready;
      @(posedge clk_i); #1;
    end while (!hs && cyc - t0 < 300);
    if (!hs) chk("aw_timeout", 0, 1);
    aw_valid_s = 1'b0;
  endtask

  task automatic drive_w(input burst_t b);
    bit hs;
    int t0;
    for (int i = 0; i <= int'(b.len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        w_valid_s = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk_i); #1; end
      end
      w_s.data  = {$urandom, $urandom};
      w_s.strb  = 8'($urandom);
      w_s.last  = (i == int'(b.len));
      w_valid_s = 1'b1;
      t0 = cyc;
      do begin
        @(negedge clk_i); hs = axi_rsp.w_ready;
        @(posedge clk_i); #1;
      end while (!hs && cyc - t0 < 300);
      if (!hs) begin
        chk("w_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic run(input bit do_aw, input bit do_w);
    fork
      begin
        if (do_aw) while (aw_list.size() > 0) drive_aw(aw_list.pop_front());
      end
      begin
        if (do_w) while (w_list.size() > 0) drive_w(w_list.pop_front());
        w_valid_s = 1'b0;
      end
    join
  endtask

  task automatic drain();
    int t0;
    t0 = cyc;
    while ((mq.size() > 0 || exp_b.size() > 0) && cyc - t0 < 1000) @(posedge clk_i);
    if (mq.size() > 0 || exp_b.size() > 0) chk("drain_timeout", 0, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_last.delete();
    log_b.delete();
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] bt, input logic [3:0] id, input logic [5:0] at);
    burst_t b;
    b = '{a, l, s, bt, id, at};
    aw_list.push_back(b);
    w_list.push_back(b);
  endtask

  logic [31:0] exp_a[4];
  logic [7:0]  rl;
  logic [1:0]  rb;
  bit          hs;
  int          t0;

  initial begin
    rst_ni = 1'b0; aw_s = '0; aw_valid_s = 1'b0; w_s = '0; w_valid_s = 1'b0;
    qr_mode = 0; br_mode = 0; gaps = 0;
    #1;
    chk("rst_aw_ready", axi_rsp.aw_ready, 1);
    chk("rst_w_ready", axi_rsp.w_ready, 0);
    chk("rst_b_valid", axi_rsp.b_valid, 0);
    chk("rst_q_valid", rq.q_valid, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("ar_ready", axi_rsp.ar_ready, 0);
    chk("r_valid", axi_rsp.r_valid, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end

    // single INCR beat
    clear_logs();
    push_burst(32'h1000, 8'd0, 3'd3, 2'd1, 4'd5, 6'd0);
    run(1, 1); drain();
    chk("single_n", log_addr.size(), 1);
    chk("single_addr", log_addr.size() > 0 ? log_addr[0] : 'x, 32'h1000);
    chk("single_last", log_last.size() > 0 ? log_last[0] : 'x, 1);
    chk("single_bid", log_b.size() > 0 ? log_b[0].id : 'x, 5);
    chk("single_bresp", log_b.size() > 0 ? log_b[0].resp : 'x, 0);

    // INCR burst
    clear_logs();
    push_burst(32'h1004, 8'd3, 3'd3, 2'd1, 4'd2, 6'd0);
    run(1, 1); drain();
    exp_a[0] = 32'h1004; exp_a[1] = 32'h1008; exp_a[2] = 32'h1010; exp_a[3] = 32'h1018;
    for (int i = 0; i < 4; i++) begin
      chk("incr_addr", i < log_addr.size() ? log_addr[i] : 'x, exp_a[i]);
      chk("incr_last", i < log_last.size() ? log_last[i] : 'x, i == 3);
    end

    // WRAP burst
    clear_logs();
    push_burst(32'h30, 8'd3, 3'd3, 2'd2, 4'd3, 6'd0);
    run(1, 1); drain();
    exp_a[0] = 32'h30; exp_a[1] = 32'h38; exp_a[2] = 32'h20; exp_a[3] = 32'h28;
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", i < log_addr.size() ? log_addr[i] : 'x, exp_a[i]);

    // AW queueing without W, then W with toggling q_ready
    clear_logs();
    for (int i = 1; i <= 4; i++) push_burst(32'h2000 + 32'(i * 'h100), 8'd1, 3'd2, 2'd1, 4'(i), 6'd0);
    run(1, 0);
    @(negedge clk_i);
    chk("aw_full_ready", axi_rsp.aw_ready, 0);
    @(posedge clk_i); #1;
    qr_mode = 1;
    run(0, 1); drain();
    qr_mode = 0;
    chk("bp_nb", log_b.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_bid", i < log_b.size() ? log_b[i].id : 'x, 4'(i + 1));

    // error beats (atomic)
    clear_logs();
    push_burst(32'h4000, 8'd1, 3'd3, 2'd1, 4'd9, 6'h20);
    run(1, 1); drain();
    chk("err_nreq", log_addr.size(), 0);
    chk("err_bid", log_b.size() > 0 ? log_b[0].id : 'x, 9);
    chk("err_bresp", log_b.size() > 0 ? log_b[0].resp : 'x, 2'b10);

    // randomised traffic
    gaps = 1; qr_mode = 2; br_mode = 1;
    for (int i = 0; i < 40; i++) begin
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'd2) rl = 8'((1 << $urandom_range(1, 3)) - 1);
      else rl = 8'($urandom_range(0, 7));
      push_burst($urandom, rl, 3'($urandom_range(0, 3)), rb, 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? 6'h20 : 6'h0);
    end
    run(1, 1); drain();
    gaps = 0; qr_mode = 0; br_mode = 0;

    // B stall and asynchronous reset
    br_mode = 2;
    repeat (2) begin @(posedge clk_i); #1; end
    push_burst(32'h5000, 8'd0, 3'd3, 2'd1, 4'd7, 6'd0);
    run(1, 1);
    repeat (2) begin @(posedge clk_i); #1; end
    chk("stall_b_pending", axi_rsp.b_valid, 1);
    aw_list.push_back('{32'h6000, 8'd1, 3'd3, 2'd1, 4'd8, 6'd0});
    run(1, 0);
    w_s.data = 64'h1111_2222_3333_4444; w_s.strb = 8'hff; w_s.last = 1'b0; w_valid_s = 1'b1;
    t0 = cyc;
    do begin
      @(negedge clk_i); hs = axi_rsp.w_ready;
      @(posedge clk_i); #1;
    end while (!hs && cyc - t0 < 100);
    chk("stall_beat0", hs, 1);
    w_s.data = 64'h5555_6666_7777_8888; w_s.last = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    chk("stall_q_valid", rq.q_valid, 0);
    chk("stall_w_ready", axi_rsp.w_ready, 0);
    chk("stall_last", last_o, 1);
    #1;
    rst_ni = 1'b0; aw_valid_s = 1'b0; w_valid_s = 1'b0;
    #1;
    chk("arst_b_valid", axi_rsp.b_valid, 0);
    chk("arst_q_valid", rq.q_valid, 0);
    chk("arst_busy", busy_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    br_mode = 0;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("post_aw_ready", axi_rsp.aw_ready, 1);
    chk("post_b_valid", axi_rsp.b_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
